// File: rtl/fwd_hazard_unit_pkg.sv
// Shared opcodes, forwarding-select encodings, FSM states and the opcode decoder for the
// EX-stage forwarding and load-use hazard unit.
package fwd_hazard_unit_pkg;

    localparam logic [5:0] OpAlu    = 6'd0;
    localparam logic [5:0] OpJ      = 6'd2;
    localparam logic [5:0] OpJal    = 6'd3;
    localparam logic [5:0] OpAddImm = 6'd8;
    localparam logic [5:0] OpLw     = 6'd35;
    localparam logic [5:0] OpSw     = 6'd43;

    localparam logic [1:0] FwdReg   = 2'b00;
    localparam logic [1:0] FwdMemwb = 2'b01;
    localparam logic [1:0] FwdExmem = 2'b10;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    typedef enum logic [1:0] {DstNone, DstRd, DstRt, DstRa} dst_sel_e;

    typedef struct packed {
        dst_sel_e dst_sel;
        logic     ld;
        logic     use_rs;
        logic     use_rt;
        logic     use_sw;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{dst_sel: DstNone, ld: 1'b0, use_rs: 1'b0, use_rt: 1'b0, use_sw: 1'b0};
        case (op)
            OpAlu: begin
                info.dst_sel = DstRd;
                info.use_rs  = 1'b1;
                info.use_rt  = 1'b1;
            end
            OpLw: begin
                info.dst_sel = DstRt;
                info.ld      = 1'b1;
                info.use_rs  = 1'b1;
            end
            OpAddImm: begin
                info.dst_sel = DstRt;
                info.use_rs  = 1'b1;
            end
            OpSw: begin
                info.use_rs = 1'b1;
                info.use_sw = 1'b1;
            end
            OpJal:   info.dst_sel = DstRa;
            OpJ:     info.dst_sel = DstNone;
            default: info.dst_sel = DstNone;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_sel_cmp.sv
// Per-source forwarding comparator: picks EX/MEM over MEM/WB over the register file.
module fwd_sel_cmp
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             used_i,
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic             ex_we_i,
    input  logic [REG_W-1:0] mem_dst_i,
    input  logic             mem_we_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FwdReg;
        if (used_i && (src_i != '0)) begin
            if (ex_we_i && (ex_dst_i == src_i)) begin
                sel_o = FwdExmem;
            end else if (mem_we_i && (mem_dst_i == src_i)) begin
                sel_o = FwdMemwb;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select generation and load-use stall control for the EX stage of a 5-stage
// MIPS pipeline; selects are registered so they line up with the instruction in EX.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush,
    output logic [1:0]       fa,
    output logic [1:0]       fb,
    output logic [1:0]       fsw,
    output logic             stall
);

    op_info_t         info;
    logic [REG_W-1:0] id_dst;
    logic             id_we;
    logic [1:0]       sel_a, sel_b, sel_s;
    logic             hazard, advance;

    // WB producers are never tracked: the register file writes before it is read.
    logic [REG_W-1:0] ex_dst_q, mem_dst_q;
    logic             ex_we_q, ex_ld_q, mem_we_q;
    state_e           state_q;
    logic [1:0]       cnt_q;

    assign info = decode_op(id_op);

    always_comb begin
        id_dst = '0;
        unique case (info.dst_sel)
            DstRd:   id_dst = id_rd;
            DstRt:   id_dst = id_rt;
            DstRa:   id_dst = REG_W'(31);
            default: id_dst = '0;
        endcase
    end

    assign id_we = (info.dst_sel != DstNone) && (id_dst != '0);

    fwd_sel_cmp #(.REG_W(REG_W)) u_cmp_rs (
        .used_i    (info.use_rs),
        .src_i     (id_rs),
        .ex_dst_i  (ex_dst_q),
        .ex_we_i   (ex_we_q),
        .mem_dst_i (mem_dst_q),
        .mem_we_i  (mem_we_q),
        .sel_o     (sel_a)
    );

    fwd_sel_cmp #(.REG_W(REG_W)) u_cmp_rt (
        .used_i    (info.use_rt),
        .src_i     (id_rt),
        .ex_dst_i  (ex_dst_q),
        .ex_we_i   (ex_we_q),
        .mem_dst_i (mem_dst_q),
        .mem_we_i  (mem_we_q),
        .sel_o     (sel_b)
    );

    fwd_sel_cmp #(.REG_W(REG_W)) u_cmp_sw (
        .used_i    (info.use_sw),
        .src_i     (id_rt),
        .ex_dst_i  (ex_dst_q),
        .ex_we_i   (ex_we_q),
        .mem_dst_i (mem_dst_q),
        .mem_we_i  (mem_we_q),
        .sel_o     (sel_s)
    );

    assign hazard = id_valid && !flush && ex_ld_q && (ex_dst_q != '0) &&
                    ((info.use_rs && (id_rs == ex_dst_q)) ||
                     ((info.use_rt || info.use_sw) && (id_rt == ex_dst_q)));

    always_comb begin
        stall = 1'b0;
        if (!reset && !flush) begin
            stall = (state_q == StStall) ? 1'b1 : hazard;
        end
    end

    assign advance = id_valid && !flush && !stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_dst_q  <= '0;
            ex_we_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_we_q  <= 1'b0;
            fa        <= FwdReg;
            fb        <= FwdReg;
            fsw       <= FwdReg;
            state_q   <= StRun;
            cnt_q     <= 2'd0;
        end else begin
            mem_dst_q <= ex_dst_q;
            mem_we_q  <= ex_we_q;
            if (advance) begin
                ex_dst_q <= id_dst;
                ex_we_q  <= id_we;
                ex_ld_q  <= info.ld && id_we;
                fa       <= sel_a;
                fb       <= sel_b;
                fsw      <= sel_s;
            end else begin
                ex_dst_q <= '0;
                ex_we_q  <= 1'b0;
                ex_ld_q  <= 1'b0;
                fa       <= FwdReg;
                fb       <= FwdReg;
                fsw      <= FwdReg;
            end
            if (flush) begin
                state_q <= StRun;
                cnt_q   <= 2'd0;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (hazard && (LOAD_STALL > 1)) begin
                            cnt_q   <= 2'(LOAD_STALL - 1);
                            state_q <= StStall;
                        end
                    end
                    StStall: begin
                        cnt_q <= cnt_q - 2'd1;
                        if (cnt_q == 2'd1) begin
                            state_q <= StRun;
                        end
                    end
                    default: state_q <= StRun;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: three instances (LOAD_STALL = 1, 2, 3) share one ID stimulus stream.
module tb_fwd_hazard_unit;

    localparam logic [5:0] ALU  = 6'd0;
    localparam logic [5:0] JAL  = 6'd3;
    localparam logic [5:0] ADDI = 6'd8;
    localparam logic [5:0] LW   = 6'd35;
    localparam logic [5:0] SW   = 6'd43;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, flush;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_rd;

    logic [1:0] fa1, fb1, fsw1, fa2, fb2, fsw2, fa3, fb3, fsw3;
    logic       stall1, stall2, stall3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    fwd_hazard_unit #(.LOAD_STALL(1), .REG_W(5)) dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .fa(fa1), .fb(fb1), .fsw(fsw1),
        .stall(stall1)
    );

    fwd_hazard_unit #(.LOAD_STALL(2), .REG_W(5)) dut2 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .fa(fa2), .fb(fb2), .fsw(fsw2),
        .stall(stall2)
    );

    fwd_hazard_unit #(.LOAD_STALL(3), .REG_W(5)) dut3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .fa(fa3), .fb(fb3), .fsw(fsw3),
        .stall(stall3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        id_valid = v;
        id_op    = op;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        flush    = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        check("reset_fa", {30'd0, fa1}, 32'd0);
        check("reset_fb_fsw", {28'd0, fb1, fsw1}, 32'd0);
        check("reset_stall", {29'd0, stall1, stall2, stall3}, 32'd0);
        reset = 1'b0;

        // Back-to-back ALU dependency: EX/MEM forwarding on both operands.
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd5, 5'd5, 5'd6, 1'b0);
        check("alu_dep_stall", {31'd0, stall1}, 32'd0);
        tick();
        check("alu_dep_fa", {30'd0, fa1}, 32'd2);
        check("alu_dep_fb", {30'd0, fb1}, 32'd2);
        check("alu_dep_fsw", {30'd0, fsw1}, 32'd0);

        // Distance-2 dependency on rt: MEM/WB forwarding.
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd8, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd3, 5'd7, 5'd10, 1'b0);
        tick();
        check("dist2_fa", {30'd0, fa1}, 32'd0);
        check("dist2_fb", {30'd0, fb1}, 32'd1);

        // Load-use: LW rt=9 then ALU rs=9, held in ID while stalled.
        drive(1'b1, LW, 5'd0, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd9, 5'd1, 5'd11, 1'b0);
        check("lu_stall_all", {29'd0, stall1, stall2, stall3}, 32'd7);
        tick();
        check("lu_bubble_fa1", {30'd0, fa1}, 32'd0);
        #1;
        check("lu_l1_release", {31'd0, stall1}, 32'd0);
        check("lu_l2_second", {31'd0, stall2}, 32'd1);
        tick();
        check("lu_l1_fa_memwb", {30'd0, fa1}, 32'd1);
        check("lu_l2_bubble_fa", {30'd0, fa2}, 32'd0);
        #1;
        check("lu_l2_release", {31'd0, stall2}, 32'd0);
        check("lu_l3_third", {31'd0, stall3}, 32'd1);
        tick();
        check("lu_l2_fa_reg", {30'd0, fa2}, 32'd0);
        #1;
        check("lu_l3_release", {31'd0, stall3}, 32'd0);
        tick();
        check("lu_l3_fa_reg", {30'd0, fa3}, 32'd0);

        // LW then SW on the same register, with flush in the SW cycle.
        drive(1'b0, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, LW, 5'd0, 5'd4, 5'd0, 1'b0);
        tick();
        drive(1'b1, SW, 5'd0, 5'd4, 5'd0, 1'b1);
        check("flush_stall", {29'd0, stall1, stall2, stall3}, 32'd0);
        tick();
        check("flush_sels", {26'd0, fa1, fb1, fsw1}, 32'd0);
        drive(1'b1, SW, 5'd0, 5'd4, 5'd0, 1'b0);
        check("post_flush_stall", {29'd0, stall1, stall2, stall3}, 32'd0);
        tick();
        check("sw_fsw_memwb", {30'd0, fsw1}, 32'd1);

        // Flush while in STALL forces the FSM back to RUN.
        drive(1'b1, LW, 5'd0, 5'd4, 5'd0, 1'b0);
        tick();
        drive(1'b1, SW, 5'd0, 5'd4, 5'd0, 1'b0);
        check("sw_lu_stall3", {31'd0, stall3}, 32'd1);
        tick();
        drive(1'b1, SW, 5'd0, 5'd4, 5'd0, 1'b1);
        check("flush_in_stall3", {31'd0, stall3}, 32'd0);
        tick();
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b0);
        check("run_after_flush3", {31'd0, stall3}, 32'd0);
        tick();

        // Store data forwarded from EX/MEM; rt is not operand B for SW.
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd12, 1'b0);
        tick();
        drive(1'b1, SW, 5'd0, 5'd12, 5'd0, 1'b0);
        tick();
        check("sw_fsw_exmem", {30'd0, fsw1}, 32'd2);
        check("sw_fb_unused", {30'd0, fb1}, 32'd0);

        // Register 0 is never forwarded.
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd0, 5'd0, 5'd13, 1'b0);
        tick();
        check("r0_sels", {28'd0, fa1, fb1}, 32'd0);

        // JAL writes r31.
        drive(1'b1, JAL, 5'd31, 5'd31, 5'd0, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd31, 5'd1, 5'd14, 1'b0);
        tick();
        check("jal_fa", {30'd0, fa1}, 32'd2);
        check("jal_fb", {30'd0, fb1}, 32'd0);

        // Same register in EX and MEM: nearest producer wins.
        drive(1'b1, ADDI, 5'd1, 5'd15, 5'd0, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd1, 5'd2, 5'd15, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd15, 5'd15, 5'd16, 1'b0);
        tick();
        check("prio_fa", {30'd0, fa1}, 32'd2);
        check("prio_fb", {30'd0, fb1}, 32'd2);

        // Invalid ID instruction never stalls.
        drive(1'b1, LW, 5'd0, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b0, ALU, 5'd9, 5'd9, 5'd1, 1'b0);
        check("invalid_no_stall", {29'd0, stall1, stall2, stall3}, 32'd0);
        tick();
        check("invalid_bubble", {26'd0, fa1, fb1, fsw1}, 32'd0);

        // Reset during STALL (LOAD_STALL=3) abandons the stall.
        drive(1'b1, LW, 5'd0, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b1, ALU, 5'd9, 5'd1, 5'd11, 1'b0);
        check("rst_lu_stall3", {31'd0, stall3}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_stall3", {31'd0, stall3}, 32'd0);
        check("rst_sels3", {26'd0, fa3, fb3, fsw3}, 32'd0);
        tick();
        check("rst_reeval_fa3", {30'd0, fa3}, 32'd0);
        #1;
        check("rst_reeval_stall3", {31'd0, stall3}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Generates the ALU operand forwarding selects (fa, fb) and the store-data select (fsw) that steer the EX-stage operand muxes of the 5-stage MIPS pipeline. It also detects load-use hazards and stalls.
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Compares each decoded ID instruction against the in-flight destinations.
- Registers the resulting selects so they are valid while that instruction sits in EX.
- Raises stall and injects bubbles for load-use hazards, and honours flush.

Parameters:
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (legal 1..3).
REG_W, 5, register specifier width.

Ports:
clock  in  1  pipeline clock.
reset  in  1  synchronous, active-high reset.
id_valid  in  1  ID stage holds a real instruction.
id_op  in  6  opcode of the ID instruction.
id_rs  in  REG_W  rs field.
id_rt  in  REG_W  rt field.
id_rd  in  REG_W  rd field.
flush  in  1  kill the ID instruction (taken jump or branch).
fa  out  2  operand-A select for the instruction now in EX.
fb  out  2  operand-B select for the instruction now in EX.
fsw  out  2  store-data select for the instruction now in EX.
stall  out  1  hold PC and IF/ID this cycle; EX receives a bubble.

Behaviour:
- Select encoding (fa, fb, fsw):
  - 00: register file / IDEXB.
  - 01: MEMWBValue.
  - 10: EXMEMALUOut.
  - 11: never driven.
- Destination register by opcode:
  - ALUop: rd.
  - LW and ADD_IMM: rt.
  - JALop: 31.
  - SW and Jop: none.
  - Register 0 is never a destination.
- Source usage by opcode:
  - rs is used by ALUop, LW, SW and ADD_IMM.
  - rt is used as B only by ALUop.
  - rt is used as store data only by SW.
  - Jop and JALop use no sources.
- Shadow stage registers: ex_dst/ex_we/ex_ld, mem_dst/mem_we, wb_dst/wb_we.
  - Each clock: mem <= ex, wb <= mem.
  - ex <= decoded ID info when the instruction advances; otherwise ex <= bubble (we=0, ld=0).
- An ID instruction advances when id_valid & !flush & !stall.
- Select computation, per used source s (rs, rt or store-data rt), evaluated in ID:
  - s != 0 & ex_we & ex_dst == s: 10 (that producer will be in MEM).
  - else s != 0 & mem_we & mem_dst == s: 01.
  - else: 00.
  - EX-stage match has priority. WB-stage producers need no forwarding (the register file writes before it is read).
- fa, fb and fsw are registered: they load the computed values on the advance edge and load 00 on any bubble edge.
  - Latency is 1 clock: the selects appear together with the instruction in EX.
- Load-use hazard: ex_ld & ex_dst != 0 & ex_dst matches any used source of a valid, non-flushed ID instruction.
- FSM states RUN and STALL, with a 2-bit counter cnt:
  - RUN, no hazard: stall=0.
  - RUN, hazard: stall=1 this cycle (combinational) and a bubble goes to EX.
    - If LOAD_STALL>1: cnt <= LOAD_STALL-1 and go to STALL.
    - Otherwise stay in RUN.
  - STALL: stall=1 and a bubble each cycle, cnt decrements; at cnt==1, return to RUN.
  - After the stall, RUN re-evaluates the held instruction.
    - LOAD_STALL=1: the load is now in MEM, giving select 01.
    - LOAD_STALL>=2: select 00.
- Flush has priority over stall:
  - stall=0 that cycle, bubble to EX, FSM forced to RUN, cnt cleared.
- Simultaneous ex and mem matches on the same register: select 10.
  - A bubble in the ex shadow never matches.
- Reset (synchronous):
  - fa, fb and fsw = 00, stall = 0.
  - All shadow we/ld = 0, FSM in RUN, cnt = 0.
  - Reset mid-stall abandons the stall.
- !id_valid without flush: treated as a bubble, stall=0.

Decomposition:
- Shared package/header: opcode constants (ALUop=0, Jop=2, JALop=3, ADD_IMM=8, LW=35, SW=43), the select encodings FWD_REG/FWD_MEMWB/FWD_EXMEM, and the FSM state encodings.
- One sub-module, fwd_sel_cmp: a combinational comparator taking one source plus the ex/mem shadows and returning a 2-bit select. It is instantiated three times (rs, rt-as-B, rt-as-store-data).

Test Plan:
- ALUop rd=5 followed by ALUop rs=5, rt=5 -> next cycle fa=10, fb=10, stall=0.
- ALUop rd=7, then an unrelated instruction, then ALUop rt=7 -> fb=01, fa=00.
- LW rt=9, then ALUop rs=9 (LOAD_STALL=1):
  - stall=1 for exactly 1 cycle, fa=00 on the bubble edge.
  - Then fa=01 when the ALUop enters EX.
  - With LOAD_STALL=2: stall=1 for 2 cycles, then fa=00.
- LW rt=4 followed by SW rt=4 with flush asserted in the same cycle -> stall=0, fa/fb/fsw=00, FSM in RUN.
- Writes to register 0 (ALUop rd=0, then ALUop rs=0), and JALop then ALUop rs=31:
  - The rd=0 case gives 00.
  - The JALop case gives fa=10.
- Reset asserted during the STALL state (LOAD_STALL=3) -> the next cycle has stall=0 and all selects 00, and the held instruction is re-evaluated with no hazard.
